// File: rtl/pic_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pic_bus_pkg
//  Description : Shared types and constants for the PIC data bus buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package pic_bus_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADDR_W     = 1;
  localparam int DEF_FIFO_DEPTH = 4;

  // Read-side handshake states
  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_DRAIN = 2'd1,
    RD_REQ   = 2'd2,
    RD_DRIVE = 2'd3
  } rd_state_t;

  // Pointer width: one extra wrap bit above the slot index
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pic_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pic_sync_fifo
//  Description : Small first-word-fall-through write queue. A push into a
//                full queue is only taken when a pop happens in the same
//                cycle; otherwise it is reported on 'dropped'.
//  Revision    : 1.0  initial release
// ============================================================================
module pic_sync_fifo
  import pic_bus_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                   (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);
  assign do_pop  = pop & ~empty;
  // The slot being vacated by a same-cycle pop makes room for the push
  assign do_push = push & (~full | do_pop);
  assign dropped = push & ~do_push;
  assign head    = mem[rptr[IDX_W-1:0]];

  // Pointer advance; wrap bit distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[IDX_W-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/pic_data_bus_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pic_data_bus_buffer
//  Description : Clocked PIC data bus buffer. CPU writes are edge detected,
//                tagged with A0 and queued for control logic; CPU reads wait
//                for the write queue to drain, then request data from control
//                and drive it back through a registered output enable.
//  Revision    : 1.0  initial release
// ============================================================================
module pic_data_bus_buffer
  import pic_bus_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ds_in,
  output logic [DATA_W-1:0] ds_out,
  output logic              ds_oe,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              wr_flag,
  input  logic              rd_flag,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic              fifo_full,
  output logic              overflow,
  output logic              proto_err,
  input  logic              clr_err
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic               wr_q;
  logic               rd_q;
  logic               wr_rise;
  logic               rd_rise;
  logic               fifo_empty;
  logic               fifo_drop;
  logic [ENTRY_W-1:0] fifo_head;
  rd_state_t          state;
  rd_state_t          state_nxt;
  logic               latch_addr;
  logic               capture;
  logic               release_oe;

  assign wr_rise = wr_flag & ~wr_q;
  assign rd_rise = rd_flag & ~rd_q;

  // Flag history for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= wr_flag;
      rd_q <= rd_flag;
    end
  end

  pic_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_rise),
    .pop     (wr_ready),
    .din     ({addr_in, ds_in}),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .dropped (fifo_drop)
  );

  assign wr_valid           = ~fifo_empty;
  assign {wr_addr, wr_data} = fifo_head;
  assign rd_req             = (state == RD_REQ);

  // Read FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RD_IDLE;
    else        state <= state_nxt;
  end

  // Read FSM next state and datapath strobes
  always_comb begin
    state_nxt  = state;
    latch_addr = 1'b0;
    capture    = 1'b0;
    release_oe = 1'b0;
    case (state)
      RD_IDLE: begin
        // A read colliding with a write is dropped; the write wins
        if (rd_rise && !wr_rise) begin
          state_nxt  = RD_DRAIN;
          latch_addr = 1'b1;
        end
      end
      RD_DRAIN: begin
        // A write arriving now lands in the queue, so keep draining
        if (!rd_flag)                     state_nxt = RD_IDLE;
        else if (!wr_valid && !wr_rise)   state_nxt = RD_REQ;
      end
      RD_REQ: begin
        if (!rd_flag) begin
          state_nxt = RD_IDLE;
        end else if (rd_ack) begin
          state_nxt = RD_DRIVE;
          capture   = 1'b1;
        end
      end
      RD_DRIVE: begin
        if (!rd_flag) begin
          state_nxt  = RD_IDLE;
          release_oe = 1'b1;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  // Read address, output data and output enable registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      ds_out  <= '0;
      ds_oe   <= 1'b0;
    end else begin
      if (latch_addr) rd_addr <= addr_in;
      if (capture) begin
        ds_out <= rd_data;
        ds_oe  <= 1'b1;
      end else if (release_oe) begin
        ds_oe  <= 1'b0;
      end
    end
  end

  // Sticky overflow (a new drop beats a clear) and collision pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (fifo_drop)    overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      proto_err <= wr_rise & rd_rise;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pic_data_bus_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pic_data_bus_buffer
//  Description : Self-checking bench for pic_data_bus_buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pic_data_bus_buffer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 1;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] ds_in;
  logic [DATA_W-1:0] ds_out;
  logic              ds_oe;
  logic [ADDR_W-1:0] addr_in;
  logic              wr_flag;
  logic              rd_flag;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_valid;
  logic              wr_ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              fifo_full;
  logic              overflow;
  logic              proto_err;
  logic              clr_err;

  int checks = 0;
  int fails  = 0;

  pic_data_bus_buffer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ds_in     (ds_in),
    .ds_out    (ds_out),
    .ds_oe     (ds_oe),
    .addr_in   (addr_in),
    .wr_flag   (wr_flag),
    .rd_flag   (rd_flag),
    .wr_data   (wr_data),
    .wr_addr   (wr_addr),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .proto_err (proto_err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    addr_in = a; ds_in = d; wr_flag = 1'b1;
    tick();
    wr_flag = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ds_in = '0; addr_in = '0; wr_flag = 0; rd_flag = 0;
    wr_ready = 0; rd_ack = 0; rd_data = '0; clr_err = 0;
    tick(); tick();
    checks++; if (ds_out !== 8'h00) begin fails++; $display("FAIL reset.ds_out: got %h expected 00", ds_out); end
    checks++; if ({ds_oe, rd_req, wr_valid, fifo_full, overflow, proto_err} !== 6'b0) begin
      fails++; $display("FAIL reset.flags: got oe=%b req=%b valid=%b full=%b ovf=%b perr=%b expected all 0",
                        ds_oe, rd_req, wr_valid, fifo_full, overflow, proto_err);
    end
    checks++; if (rd_addr !== 1'b0) begin fails++; $display("FAIL reset.rd_addr: got %b expected 0", rd_addr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fifo_order();
    logic [8:0] exp [3];
    exp[0] = {1'b0, 8'h13}; exp[1] = {1'b1, 8'h08}; exp[2] = {1'b1, 8'hFF};
    wr_ready = 0;
    addr_in = 0; ds_in = 8'h13; wr_flag = 1;
    tick();
    checks++; if (wr_valid !== 1'b1) begin fails++; $display("FAIL order.latency: wr_valid got %b expected 1", wr_valid); end
    wr_flag = 0; tick();
    do_write(1'b1, 8'h08);
    do_write(1'b1, 8'hFF);
    checks++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL order.full: got %b expected 0", fifo_full); end
    wr_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_valid !== 1'b1 || {wr_addr, wr_data} !== exp[i]) begin
        fails++; $display("FAIL order.head%0d: got valid=%b %h expected valid=1 %h", i, wr_valid, {wr_addr, wr_data}, exp[i]);
      end
      tick();
    end
    checks++; if (wr_valid !== 1'b0) begin fails++; $display("FAIL order.empty: wr_valid got %b expected 0", wr_valid); end
    wr_ready = 0;
  endtask

  task automatic test_overflow();
    wr_ready = 0;
    for (int i = 0; i < 4; i++) do_write(i[0], 8'h21 + i[7:0]);
    checks++; if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
      fails++; $display("FAIL ovf.full4: got full=%b ovf=%b expected full=1 ovf=0", fifo_full, overflow);
    end
    do_write(1'b0, 8'h99);
    checks++; if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
      fails++; $display("FAIL ovf.drop: got full=%b ovf=%b expected full=1 ovf=1", fifo_full, overflow);
    end
    wr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_valid !== 1'b1 || wr_data !== 8'h21 + i[7:0] || wr_addr !== i[0]) begin
        fails++; $display("FAIL ovf.entry%0d: got valid=%b a=%b d=%h expected 1 %b %h", i, wr_valid, wr_addr, wr_data, i[0], 8'h21 + i[7:0]);
      end
      tick();
    end
    checks++; if (wr_valid !== 1'b0) begin fails++; $display("FAIL ovf.empty: wr_valid got %b expected 0", wr_valid); end
    wr_ready = 0;
    clr_err = 1; tick(); clr_err = 0;
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf.clear: got %b expected 0", overflow); end
  endtask

  task automatic test_read_drain();
    wr_ready = 0;
    do_write(1'b0, 8'h55);
    do_write(1'b1, 8'h66);
    addr_in = 1; rd_flag = 1;
    tick();
    tick();
    tick();
    checks++; if (rd_req !== 1'b0) begin fails++; $display("FAIL drain.hold: rd_req got %b expected 0", rd_req); end
    wr_ready = 1;
    tick();
    checks++; if (rd_req !== 1'b0) begin fails++; $display("FAIL drain.pop1: rd_req got %b expected 0", rd_req); end
    tick();
    checks++; if (rd_req !== 1'b0 || wr_valid !== 1'b0) begin
      fails++; $display("FAIL drain.pop2: got req=%b valid=%b expected 0 0", rd_req, wr_valid);
    end
    tick();
    wr_ready = 0;
    checks++; if (rd_req !== 1'b1 || rd_addr !== 1'b1) begin
      fails++; $display("FAIL drain.req: got req=%b addr=%b expected 1 1", rd_req, rd_addr);
    end
    rd_data = 8'hA5; rd_ack = 1;
    tick();
    rd_ack = 0; rd_data = 8'h00;
    checks++; if (ds_oe !== 1'b1 || ds_out !== 8'hA5 || rd_req !== 1'b0) begin
      fails++; $display("FAIL drain.capture: got oe=%b out=%h req=%b expected 1 a5 0", ds_oe, ds_out, rd_req);
    end
    tick(); tick();
    checks++; if (ds_oe !== 1'b1 || ds_out !== 8'hA5) begin
      fails++; $display("FAIL drain.drive: got oe=%b out=%h expected 1 a5", ds_oe, ds_out);
    end
    rd_flag = 0;
    tick();
    checks++; if (ds_oe !== 1'b0 || ds_out !== 8'hA5) begin
      fails++; $display("FAIL drain.release: got oe=%b out=%h expected 0 a5", ds_oe, ds_out);
    end
  endtask

  task automatic test_abort();
    addr_in = 0; rd_flag = 1;
    tick(); tick();
    checks++; if (rd_req !== 1'b1) begin fails++; $display("FAIL abort.req: got %b expected 1", rd_req); end
    rd_flag = 0;
    tick();
    checks++; if (rd_req !== 1'b0 || ds_oe !== 1'b0) begin
      fails++; $display("FAIL abort.drop: got req=%b oe=%b expected 0 0", rd_req, ds_oe);
    end
    rd_ack = 1; rd_data = 8'h5A;
    tick();
    rd_ack = 0;
    checks++; if (rd_req !== 1'b0 || ds_oe !== 1'b0) begin
      fails++; $display("FAIL abort.late_ack: got req=%b oe=%b expected 0 0", rd_req, ds_oe);
    end
    // Only an idle FSM reaches REQ two cycles after a fresh read strobe
    rd_flag = 1;
    tick(); tick();
    checks++; if (rd_req !== 1'b1) begin fails++; $display("FAIL abort.idle: rd_req got %b expected 1", rd_req); end
    rd_flag = 0;
    tick();
  endtask

  task automatic test_proto_err();
    wr_ready = 0;
    addr_in = 1; ds_in = 8'h3C; wr_flag = 1; rd_flag = 1;
    tick();
    checks++; if (proto_err !== 1'b1 || wr_valid !== 1'b1) begin
      fails++; $display("FAIL proto.pulse: got perr=%b valid=%b expected 1 1", proto_err, wr_valid);
    end
    tick();
    checks++; if (proto_err !== 1'b0 || rd_req !== 1'b0) begin
      fails++; $display("FAIL proto.once: got perr=%b req=%b expected 0 0", proto_err, rd_req);
    end
    tick(); tick();
    checks++; if (rd_req !== 1'b0 || {wr_addr, wr_data} !== 9'h13C) begin
      fails++; $display("FAIL proto.noread: got req=%b head=%h expected 0 13c", rd_req, {wr_addr, wr_data});
    end
    wr_flag = 0; rd_flag = 0; wr_ready = 1;
    tick();
    wr_ready = 0;
    checks++; if (wr_valid !== 1'b0) begin fails++; $display("FAIL proto.single: wr_valid got %b expected 0", wr_valid); end
  endtask

  task automatic test_reset_mid();
    wr_ready = 0; addr_in = 0; rd_flag = 1;
    tick(); tick();
    rd_ack = 1; rd_data = 8'hC3;
    tick();
    rd_ack = 0;
    do_write(1'b0, 8'h11);
    do_write(1'b1, 8'h22);
    checks++; if (ds_oe !== 1'b1 || wr_valid !== 1'b1) begin
      fails++; $display("FAIL rstmid.setup: got oe=%b valid=%b expected 1 1", ds_oe, wr_valid);
    end
    rst_n = 0;
    #1;
    checks++; if (ds_oe !== 1'b0 || wr_valid !== 1'b0 || rd_req !== 1'b0) begin
      fails++; $display("FAIL rstmid.async: got oe=%b valid=%b req=%b expected 0 0 0", ds_oe, wr_valid, rd_req);
    end
    rd_flag = 0;
    tick();
    rst_n = 1;
    tick();
    rd_flag = 1;
    tick(); tick();
    checks++; if (rd_req !== 1'b1 || ds_oe !== 1'b0) begin
      fails++; $display("FAIL rstmid.idle: got req=%b oe=%b expected 1 0", rd_req, ds_oe);
    end
    rd_flag = 0;
    tick();
  endtask

  // Random writes/pops/clears against a queue-based model of the write path
  task automatic test_random();
    logic [8:0] q [$];
    logic       model_ovf;
    logic       prev_wr;
    logic       rise;
    logic       pop;
    logic       drop;
    logic [8:0] head;
    clr_err = 1; tick(); clr_err = 0;
    model_ovf = 1'b0;
    prev_wr   = wr_flag;
    for (int n = 0; n < 400; n++) begin
      wr_flag  = ($urandom_range(0, 2) == 0);
      ds_in    = 8'($urandom);
      addr_in  = 1'($urandom);
      wr_ready = ($urandom_range(0, 3) == 0);
      clr_err  = ($urandom_range(0, 7) == 0);
      rise = wr_flag && !prev_wr;
      pop  = (q.size() > 0) && wr_ready;
      drop = rise && (q.size() == DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      if (rise && !drop) q.push_back({addr_in, ds_in});
      if (drop)         model_ovf = 1'b1;
      else if (clr_err) model_ovf = 1'b0;
      prev_wr = wr_flag;
      tick();
      checks++;
      if (wr_valid !== (q.size() != 0) || fifo_full !== (q.size() == DEPTH) || overflow !== model_ovf) begin
        fails++; $display("FAIL rand.status%0d: got valid=%b full=%b ovf=%b expected %b %b %b",
                          n, wr_valid, fifo_full, overflow, q.size() != 0, q.size() == DEPTH, model_ovf);
      end
      if (q.size() != 0) begin
        head = q[0];
        checks++;
        if ({wr_addr, wr_data} !== head) begin
          fails++; $display("FAIL rand.head%0d: got %h expected %h", n, {wr_addr, wr_data}, head);
        end
      end
    end
    wr_flag = 0; clr_err = 0; wr_ready = 1;
    tick(); tick(); tick(); tick(); tick();
    wr_ready = 0;
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow();
    test_read_drain();
    test_abort();
    test_proto_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pic_data_bus_buffer.md
Name: pic_data_bus_buffer

Overview:
- Clocked, parametrised successor to the PIC's combinational data bus buffer.
- CPU writes: edge-detected, tagged with A0, queued in a small FIFO, and handed to control logic via a valid/ready handshake.
- CPU reads: request/acknowledge exchange with control; the read is held off until all queued writes have drained, so status reads always reflect prior writes.
- Output data is registered and driven through an explicit output enable; the top level owns the tri-state pad.

Parameters:
- DATA_W, 8, width of the CPU data bus.
- FIFO_DEPTH, 4, write-queue entries; must be a power of two and at least 2.
- ADDR_W, 1, width of the address tag (A0) carried with writes and reads.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ds_in  in  DATA_W  D0-D7 from the CPU.
- ds_out  out  DATA_W  registered read data to the CPU.
- ds_oe  out  1  high while ds_out must be driven onto the bus.
- addr_in  in  ADDR_W  A0 from the CPU, sampled with each flag edge.
- wr_flag  in  1  write strobe from the read/write logic, level, active high.
- rd_flag  in  1  read strobe from the read/write logic, level, active high.
- wr_data  out  DATA_W  FIFO head data to control.
- wr_addr  out  ADDR_W  FIFO head address tag.
- wr_valid  out  1  FIFO non-empty.
- wr_ready  in  1  control accepts the head entry this cycle.
- rd_req  out  1  read request to control.
- rd_addr  out  ADDR_W  address captured at the rd_flag rising edge.
- rd_ack  in  1  control presents valid rd_data this cycle.
- rd_data  in  DATA_W  read data from control.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- overflow  out  1  sticky: a write was dropped.
- proto_err  out  1  one-cycle pulse on simultaneous rd/wr rising edges.
- clr_err  in  1  clears overflow.

Behaviour:
- Reset (async assert, sync release): outputs listed here are 0: ds_out, ds_oe, rd_req, rd_addr, wr_valid, fifo_full, overflow, proto_err. FIFO empty; read FSM in IDLE; flag history registers 0.
- Edge detection: wr_q and rd_q register the flags each cycle. wr_rise = wr_flag & ~wr_q; rd_rise = rd_flag & ~rd_q. A held level produces exactly one event.
- Write push: on wr_rise, {addr_in, ds_in} is written at the tail. wr_valid goes high the following cycle (1-cycle latency).
- Write pop: pop occurs when wr_valid & wr_ready. Data is first-word fall-through: head is visible combinationally from storage.
- Pointers: width log2(FIFO_DEPTH)+1, wrapping naturally. full = MSBs differ and LSBs equal; empty = pointers equal.
- Full boundary: push while full is accepted only if a pop occurs in the same cycle. Otherwise the write is dropped, overflow is set, and the pointers are unchanged.
- Overflow priority: clr_err clears overflow. A new drop in the same cycle as clr_err wins, so overflow stays 1.
- Simultaneous wr_rise and rd_rise: the write is pushed, the read is ignored, and proto_err pulses for one cycle.
- Read FSM states: IDLE, DRAIN, REQ, DRIVE.
- IDLE: on rd_rise (and no wr_rise), latch rd_addr = addr_in and go to DRAIN.
- DRAIN: wait for FIFO empty with no pop pending, then go to REQ. Leaving DRAIN requires wr_valid==0 in the current cycle.
- REQ: rd_req = 1, held until rd_ack. On rd_ack: ds_out <= rd_data, ds_oe <= 1, rd_req <= 0, go to DRIVE. Minimum rd_rise-to-ds_oe latency is 3 cycles (DRAIN 1, REQ 1, capture).
- DRIVE: ds_oe = 1 and ds_out stable. When rd_flag goes low, ds_oe <= 0 next cycle and the FSM returns to IDLE; ds_out keeps its last value.
- Abort: rd_flag low while in DRAIN or REQ → IDLE next cycle, rd_req drops, and ds_oe never asserts.
- rd_ack outside REQ: ignored.
- wr_rise outside IDLE: pushed normally. In DRAIN it extends the drain.
- ds_oe only ever asserts in DRIVE.
- Reset mid-operation: all state returns to reset values immediately; queued writes are discarded.

Decomposition:
- Package pic_bus_pkg holds:
  - the read FSM state enum (IDLE/DRAIN/REQ/DRIVE, 2 bits);
  - default DATA_W/ADDR_W constants;
  - a localparam function for pointer width.
- One natural sub-module: pic_sync_fifo, parametrised by width (ADDR_W+DATA_W) and depth. It provides push, pop, full, empty and head, and implements the full-with-simultaneous-pop rule.
- Edge detection, the read FSM and the error flags stay in the top module.

Test Plan:
- Reset then 3 writes (0x13, 0x08, 0xFF; A0=0,1,1) with wr_ready=0 → wr_valid=1; fifo_full=0. Raising wr_ready pops them in order with the correct wr_addr.
- 5 writes with wr_ready=0, DEPTH=4 → fifo_full=1 after the 4th. The 5th is dropped, overflow=1, and entries 1-4 are intact. clr_err → overflow=0.
- 2 writes queued, then rd_rise with A0=1 → rd_req stays 0 until both entries are popped. Then rd_req=1 and rd_addr=1. rd_ack with 0xA5 → ds_out=0xA5 and ds_oe=1 until rd_flag falls, then 0 next cycle.
- rd_rise, then rd_flag dropped while in REQ before ack → rd_req=0 and ds_oe stays 0. A late rd_ack is ignored and the FSM is in IDLE.
- wr_flag and rd_flag rising the same cycle → one FIFO push, proto_err pulses for 1 cycle, and no rd_req.
- rst_n asserted while in DRIVE with 2 entries queued → immediately ds_oe=0, wr_valid=0, rd_req=0; after release the FSM is in IDLE.
